axi_lite_gpio_slave: RTL

AXI4-Lite responder exposing a two-channel GPIO register file: the memory-mapped peripheral a bus master addresses at its GPIO base address. Channel 1 drives LEDs, with a per-bit tri-state; channel 2 samples push-buttons through a 2-flop synchronizer. Sits under `design_1` behind the AXI interconnect, directly driven by the master VIP in simulation.

---
 rtl/axi_lite_gpio_pkg.sv | 37 +++
 rtl/gpio_sync.sv | 23 ++
 rtl/axi_lite_gpio_slave.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO slave: register offsets, response
// codes, FSM state types and the byte-strobe merge helper.
package axi_lite_gpio_pkg;

  localparam logic [3:0] DATA1_OFF = 4'h0;
  localparam logic [3:0] TRI1_OFF  = 4'h4;
  localparam logic [3:0] DATA2_OFF = 4'h8;
  localparam logic [3:0] TRI2_OFF  = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Byte lanes with a set strobe take the new data; the rest keep the old value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, synchronous reset to 0.
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge aclk) begin
    if (areset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite slave with a two-channel GPIO register file: channel 1 drives LEDs
// with per-bit tri-state, channel 2 samples buttons through a synchronizer.
module axi_lite_gpio_slave #(
  parameter int C1_WIDTH   = 16,
  parameter int C2_WIDTH   = 5,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [C1_WIDTH-1:0]   gpio1_o,
  output logic [C1_WIDTH-1:0]   gpio1_t,
  input  logic [C1_WIDTH-1:0]   gpio1_i,
  input  logic [C2_WIDTH-1:0]   gpio2_i
);

  import axi_lite_gpio_pkg::*;

  wr_state_e w_state, w_next;
  rd_state_e r_state, r_next;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [31:0]           w_data_q, wr_data;
  logic [3:0]            w_strb_q, wr_strb;
  logic                  wr_bad, rd_bad;
  logic [C1_WIDTH-1:0]   data1_q, tri1_q, sync1;
  logic [C2_WIDTH-1:0]   tri2_q, sync2;
  logic [31:0]           data1_merged, tri1_merged, tri2_merged, rd_word;
  logic [1:0]            rd_resp;

  gpio_sync #(.WIDTH(C1_WIDTH)) u_sync1 (.aclk(aclk), .areset(areset), .d(gpio1_i), .q(sync1));
  gpio_sync #(.WIDTH(C2_WIDTH)) u_sync2 (.aclk(aclk), .areset(areset), .d(gpio2_i), .q(sync2));

  // Readies are forced low while reset is held so nothing handshakes mid-reset.
  assign s_axi_awready = !areset && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign s_axi_wready  = !areset && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign s_axi_arready = !areset && (r_state == R_IDLE);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_rvalid  = (r_state == R_DATA);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // ---------------- write path ----------------
  always_ff @(posedge aclk) begin
    // NOTE: state flops use non-blocking <= so every flop samples pre-edge values.
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults come first so every path assigns each output; no latch is inferred.
    w_next = w_state;
    commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs)  begin commit = 1'b1; w_next = W_RESP; end
      W_HAVE_W:  if (aw_hs) begin commit = 1'b1; w_next = W_RESP; end
      W_RESP:    if (s_axi_bready) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  // NOTE: holding registers have no reset; they are only consumed after a handshake loads them.
  always_ff @(posedge aclk) begin
    if (aw_hs) aw_addr_q <= s_axi_awaddr;
    if (w_hs) begin
      w_data_q <= s_axi_wdata;
      w_strb_q <= s_axi_wstrb;
    end
  end

  // Whichever half arrived first was parked; the other comes straight off the bus.
  assign wr_addr = (w_state == W_HAVE_AW) ? aw_addr_q : s_axi_awaddr;
  assign wr_data = (w_state == W_HAVE_W)  ? w_data_q  : s_axi_wdata;
  assign wr_strb = (w_state == W_HAVE_W)  ? w_strb_q  : s_axi_wstrb;
  assign wr_bad  = (wr_addr >> 4) != '0;

  assign data1_merged = apply_wstrb(32'(data1_q), wr_data, wr_strb);
  assign tri1_merged  = apply_wstrb(32'(tri1_q),  wr_data, wr_strb);
  assign tri2_merged  = apply_wstrb(32'(tri2_q),  wr_data, wr_strb);

  always_ff @(posedge aclk) begin
    if (areset) begin
      data1_q     <= '0;
      tri1_q      <= '1;
      tri2_q      <= '1;
      s_axi_bresp <= RESP_OKAY;
    end else if (commit) begin
      s_axi_bresp <= wr_bad ? RESP_SLVERR : RESP_OKAY;
      if (!wr_bad) begin
        case (wr_addr[3:2])
          DATA1_OFF[3:2]: data1_q <= C1_WIDTH'(data1_merged);
          TRI1_OFF[3:2]:  tri1_q  <= C1_WIDTH'(tri1_merged);
          TRI2_OFF[3:2]:  tri2_q  <= C2_WIDTH'(tri2_merged);
          default: ;
        endcase
      end
    end
  end

  assign gpio1_o = data1_q;
  assign gpio1_t = tri1_q;

  // ---------------- read path ----------------
  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign rd_bad = (s_axi_araddr >> 4) != '0;

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (rd_bad) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (s_axi_araddr[3:2])
        DATA1_OFF[3:2]: rd_word = 32'((sync1 & tri1_q) | (data1_q & ~tri1_q));
        TRI1_OFF[3:2]:  rd_word = 32'(tri1_q);
        DATA2_OFF[3:2]: rd_word = 32'(sync2 & tri2_q);
        TRI2_OFF[3:2]:  rd_word = 32'(tri2_q);
        default:        rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rdata <= rd_word;
      s_axi_rresp <= rd_resp;
    end
  end

endmodule
